// File: rtl/tune_sequencer.sv
// Multi-tune piezo sequencer: note ROM, rests, repeat, abort and busy/done handshake.
// Drives a complementary piezo pair; both legs low while idle or resting.
module tune_sequencer #(
    parameter int FAST_SIM = 1,
    parameter int DUR_LOG2 = 22,
    parameter int PER_W    = 15,
    parameter int DUR_W    = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
    input  logic [1:0] tune_sel,
    input  logic       repeat_en,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       piezo,
    output logic       piezo_n
);

    localparam int UNIT_LOG2 = (FAST_SIM != 0) ? DUR_LOG2 - 4 : DUR_LOG2;
    localparam int ROM_W     = PER_W + 4;

    typedef enum logic {IDLE, PLAY} state_t;

    state_t             state, state_nxt;
    logic [1:0]         sel, sel_nxt;
    logic [3:0]         addr, addr_nxt;
    logic [DUR_W-1:0]   dcnt, dcnt_nxt;
    logic [PER_W-1:0]   pcnt, pcnt_nxt;
    logic               done_q, done_nxt;

    logic [ROM_W-1:0]   word;
    logic               last;
    logic [PER_W-1:0]   period;
    logic [2:0]         code;
    logic [DUR_W-1:0]   note_len;
    logic               note_end;
    logic               sounding;
    logic               high;

    // Entry layout {last, period, dur_code}; tunes packed back to back
    function automatic logic [ROM_W-1:0] rom(input logic [3:0] a);
        case (a)
            4'd0:    rom = {1'b0, PER_W'(15'h5326), 3'd1};
            4'd1:    rom = {1'b0, PER_W'(15'h4A11), 3'd1};
            4'd2:    rom = {1'b0, PER_W'(15'h45E7), 3'd1};
            4'd3:    rom = {1'b0, PER_W'(15'h4A11), 3'd2};
            4'd4:    rom = {1'b0, PER_W'(15'h45E7), 3'd0};
            4'd5:    rom = {1'b0, PER_W'(15'h5326), 3'd2};
            4'd6:    rom = {1'b0, PER_W'(15'h6EF9), 3'd0};
            4'd7:    rom = {1'b1, PER_W'(15'h5326), 3'd1};
            4'd8:    rom = {1'b0, PER_W'(15'h6EF9), 3'd0};
            4'd9:    rom = {1'b0, PER_W'(15'h0000), 3'd0};
            4'd10:   rom = {1'b1, PER_W'(15'h6EF9), 3'd0};
            4'd11:   rom = {1'b1, PER_W'(15'h5326), 3'd3};
            default: rom = '0;
        endcase
    endfunction

    function automatic logic [3:0] base(input logic [1:0] s);
        case (s)
            2'd1:    base = 4'd8;
            2'd2:    base = 4'd11;
            default: base = 4'd0;
        endcase
    endfunction

    assign word     = rom(addr);
    assign last     = word[ROM_W-1];
    assign period   = word[3 +: PER_W];
    assign code     = word[2:0];
    assign note_len = (DUR_W'(code) + DUR_W'(1)) << UNIT_LOG2;
    assign note_end = (dcnt == note_len - DUR_W'(1));

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        addr_nxt  = addr;
        dcnt_nxt  = dcnt;
        pcnt_nxt  = pcnt;
        done_nxt  = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
            dcnt_nxt  = '0;
            pcnt_nxt  = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (go) begin
                        if (tune_sel == 2'd3) begin
                            done_nxt = 1'b1;
                        end else begin
                            state_nxt = PLAY;
                            sel_nxt   = tune_sel;
                            addr_nxt  = base(tune_sel);
                            dcnt_nxt  = '0;
                            pcnt_nxt  = '0;
                        end
                    end
                end
                PLAY: begin
                    if (note_end) begin
                        dcnt_nxt = '0;
                        pcnt_nxt = '0;
                        if (!last) begin
                            addr_nxt = addr + 4'd1;
                        end else if (repeat_en) begin
                            addr_nxt = base(sel);
                        end else begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                        end
                    end else begin
                        dcnt_nxt = dcnt + DUR_W'(1);
                        if (period == '0 || pcnt == period - PER_W'(1))
                            pcnt_nxt = '0;
                        else
                            pcnt_nxt = pcnt + PER_W'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sel    <= '0;
            addr   <= '0;
            dcnt   <= '0;
            pcnt   <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            sel    <= sel_nxt;
            addr   <= addr_nxt;
            dcnt   <= dcnt_nxt;
            pcnt   <= pcnt_nxt;
            done_q <= done_nxt;
        end
    end

    // Rests and idle leave the buzzer undriven rather than inverted
    assign sounding = (state == PLAY) && (period != '0);
    assign high     = pcnt < (period >> 1);
    assign busy     = (state == PLAY);
    assign done     = done_q;
    assign piezo    = sounding && high;
    assign piezo_n  = sounding && !high;

endmodule

// File: tb/tb_tune_sequencer.sv
// Directed bench for tune_sequencer with a 4096-clock duration unit.
// Expected values are hand-derived from note periods and unit counts.
module tb_tune_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       go;
    logic [1:0] tune_sel;
    logic       repeat_en;
    logic       abort;
    logic       busy;
    logic       done;
    logic       piezo;
    logic       piezo_n;

    int n_chk  = 0;
    int n_pass = 0;
    int k      = 0;

    tune_sequencer #(
        .FAST_SIM(1),
        .DUR_LOG2(16),
        .PER_W(15),
        .DUR_W(26)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .go(go),
        .tune_sel(tune_sel),
        .repeat_en(repeat_en),
        .abort(abort),
        .busy(busy),
        .done(done),
        .piezo(piezo),
        .piezo_n(piezo_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s k=%0d got=%b exp=%b", tag, k, got, exp);
    endtask

    task automatic start(input logic [1:0] s);
        tune_sel = s;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        k = 0;
    endtask

    task automatic to_k(input int t);
        while (k < t) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        go = 1'b0;
        tune_sel = 2'd0;
        repeat_en = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pz", piezo, 1'b0);
        chk("rst_pzn", piezo_n, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // error tune, with an ignored go/tune_sel change while busy
        start(2'd2);
        chk("err_busy0", busy, 1'b1);
        chk("err_pz0", piezo, 1'b1);
        chk("err_pzn0", piezo_n, 1'b0);
        tune_sel = 2'd1;
        go = 1'b1;
        to_k(6);
        go = 1'b0;
        to_k(10642);
        chk("err_hi_end", piezo, 1'b1);
        to_k(10643);
        chk("err_lo_pz", piezo, 1'b0);
        chk("err_lo_pzn", piezo_n, 1'b1);
        to_k(16383);
        chk("err_busy_last", busy, 1'b1);
        chk("err_nodone", done, 1'b0);
        to_k(16384);
        chk("err_done", done, 1'b1);
        chk("err_busy_off", busy, 1'b0);
        chk("err_idle_pz", piezo, 1'b0);
        chk("err_idle_pzn", piezo_n, 1'b0);
        to_k(16385);
        chk("err_done_1cyc", done, 1'b0);

        // ack tune, repeat for one extra pass
        repeat_en = 1'b1;
        start(2'd1);
        chk("ack_pz0", piezo, 1'b1);
        to_k(4095);
        chk("ack_tone_end", piezo, 1'b1);
        to_k(4096);
        chk("ack_rest_pz", piezo, 1'b0);
        chk("ack_rest_pzn", piezo_n, 1'b0);
        chk("ack_rest_busy", busy, 1'b1);
        to_k(8192);
        chk("ack_tone2", piezo, 1'b1);
        to_k(12288);
        chk("rep_busy", busy, 1'b1);
        chk("rep_nodone", done, 1'b0);
        chk("rep_pz", piezo, 1'b1);
        to_k(14000);
        repeat_en = 1'b0;
        to_k(16383);
        chk("rep_tone_end", piezo, 1'b1);
        to_k(16384);
        chk("rep_rest_pz", piezo, 1'b0);
        chk("rep_rest_pzn", piezo_n, 1'b0);
        to_k(24575);
        chk("rep_busy_last", busy, 1'b1);
        chk("rep_nodone2", done, 1'b0);
        to_k(24576);
        chk("rep_done", done, 1'b1);
        chk("rep_busy_off", busy, 1'b0);

        // charge tune into note 3, then abort with a simultaneous go
        start(2'd0);
        chk("chg_busy0", busy, 1'b1);
        to_k(24575);
        chk("chg_n2_end", piezo, 1'b1);
        to_k(24576 + 9479);
        chk("chg_n3_hi", piezo, 1'b1);
        to_k(24576 + 9480);
        chk("chg_n3_lo", piezo, 1'b0);
        chk("chg_n3_lon", piezo_n, 1'b1);
        to_k(34576);
        abort = 1'b1;
        go = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        go = 1'b0;
        chk("abt_busy", busy, 1'b0);
        chk("abt_pz", piezo, 1'b0);
        chk("abt_pzn", piezo_n, 1'b0);
        chk("abt_nodone", done, 1'b0);
        @(negedge clk);
        chk("abt_go_ign", busy, 1'b0);
        chk("abt_nodone2", done, 1'b0);

        // fresh start, then asynchronous reset mid-note
        start(2'd0);
        chk("fresh_busy", busy, 1'b1);
        chk("fresh_pz", piezo, 1'b1);
        to_k(100);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_pz", piezo, 1'b0);
        chk("arst_pzn", piezo_n, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // empty tune
        start(2'd3);
        chk("t3_done", done, 1'b1);
        chk("t3_busy", busy, 1'b0);
        chk("t3_pz", piezo, 1'b0);
        to_k(1);
        chk("t3_done_1cyc", done, 1'b0);
        chk("t3_busy2", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
